// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board-level pin conditioning between FPGA pins and the SoC GPIO.
// Active-low pushbuttons are synchronised and debounced into clean levels,
// one-cycle press pulses and sticky press events. LEDs are driven from a GPIO
// word in one of four global display modes: direct, blink, PWM-dimmed or off.
//
// Key path per channel:
//   key_raw -> 2-flop sync (reset to released) -> invert -> debounce -> stable
//   stable -> key_level (combinational copy)
//   stable rising edge -> registered key_press pulse -> sticky key_event
//
// LED path:
//   free-running blink timer and PWM counter feed a mode mux whose result is
//   registered into led_out, so any input change shows up one cycle later.
//
// There are no handshakes on this block. Every input is sampled each cycle and
// every output is a level, except key_press, which is a single-cycle strobe.
module board_io_ctrl #(
  parameter int NKEY            = 4,
  parameter int NLED            = 18,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_DIV       = 12500000,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NKEY-1:0]     key_raw,
  output logic [NKEY-1:0]     key_level,
  output logic [NKEY-1:0]     key_press,
  output logic [NKEY-1:0]     key_event,
  input  logic [NKEY-1:0]     key_clr,
  input  logic [NLED-1:0]     led_data,
  input  logic [1:0]          led_mode,
  input  logic [PWM_BITS-1:0] led_duty,
  output logic [NLED-1:0]     led_out
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Blink counter runs 0..BLINK_DIV-1; keep at least one bit for BLINK_DIV=1.
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  // Display mode encodings on led_mode.
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_PWM    = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  // ---------------------------------------------------------------------------
  // Key synchroniser
  // ---------------------------------------------------------------------------

  logic [NKEY-1:0] sync_q1;
  logic [NKEY-1:0] sync_q2;
  logic [NKEY-1:0] pressed;

  // Two-flop synchroniser; both stages reset to the released (high) level so a
  // key held through reset is seen as a fresh press after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Pins are active-low; internally 1 means pressed.
  assign pressed = ~sync_q2;

  // ---------------------------------------------------------------------------
  // Per-channel debounce
  // ---------------------------------------------------------------------------

  logic [NKEY-1:0] stable;

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    logic [DB_W-1:0] db_cnt;
    logic            stable_r;

    // Count consecutive cycles where the synchronised key differs from the
    // accepted state; any agreement (including a one-cycle bounce) restarts
    // the count, and a full window of disagreement adopts the new value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt   <= '0;
        stable_r <= 1'b0;
      end else if (pressed[i] == stable_r) begin
        db_cnt   <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        stable_r <= pressed[i];
      end else begin
        db_cnt   <= db_cnt + 1'b1;
      end
    end

    assign stable[i] = stable_r;
  end

  assign key_level = stable;

  // ---------------------------------------------------------------------------
  // Press pulse and sticky event
  // ---------------------------------------------------------------------------

  logic [NKEY-1:0] stable_q;

  // Registered rising-edge detect on the debounced level; releases are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q  <= '0;
      key_press <= '0;
    end else begin
      stable_q  <= stable;
      key_press <= stable & ~stable_q;
    end
  end

  // Sticky flag: a press in the same cycle as a clear keeps the flag set, so
  // software clearing an old event can never swallow a new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_event <= '0;
    end else begin
      key_event <= (key_event & ~key_clr) | key_press;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timer
  // ---------------------------------------------------------------------------

  logic [BL_W-1:0] blink_cnt;
  logic            blink_phase;

  // Free-running half-period timer; phase starts high so blinking LEDs begin
  // in the on half. Runs in every mode so a mode switch never restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  // Free-running PWM counter wrapping at 2^PWM_BITS; never realigned to duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Duty 0 never lights; full-scale duty lights all but one slot per period.
  assign pwm_on = (pwm_cnt < led_duty);

  // ---------------------------------------------------------------------------
  // LED mux and output register
  // ---------------------------------------------------------------------------

  logic [NLED-1:0] led_next;

  // Select the pattern for the current display mode.
  always_comb begin
    led_next = '0;
    case (led_mode)
      MODE_DIRECT: led_next = led_data;
      MODE_BLINK:  led_next = led_data & {NLED{blink_phase}};
      MODE_PWM:    led_next = led_data & {NLED{pwm_on}};
      MODE_OFF:    led_next = '0;
      default:     led_next = '0;
    endcase
  end

  // Register the pin drive so the LED pins toggle glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else begin
      led_out <= led_next;
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed testbench for board_io_ctrl with small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_board_io_ctrl;

  localparam int NKEY = 4;
  localparam int NLED = 18;
  localparam int DB   = 4;
  localparam int BD   = 3;
  localparam int PB   = 3;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] key_level;
  logic [NKEY-1:0] key_press;
  logic [NKEY-1:0] key_event;
  logic [NKEY-1:0] key_clr;
  logic [NLED-1:0] led_data;
  logic [1:0]      led_mode;
  logic [PB-1:0]   led_duty;
  logic [NLED-1:0] led_out;

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  // Rising edges since the last reset release; drives the LED reference model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  board_io_ctrl #(
    .NKEY(NKEY), .NLED(NLED), .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_level(key_level),
    .key_press(key_press), .key_event(key_event), .key_clr(key_clr),
    .led_data(led_data), .led_mode(led_mode), .led_duty(led_duty), .led_out(led_out)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    key_raw  = '0;
    key_clr  = '0;
    led_data = '1;
    led_mode = 2'b00;
    led_duty = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (key_level !== 4'h0) begin bad++; $display("FAIL rst_level got=%h exp=0", key_level); end
    total++; if (key_press !== 4'h0) begin bad++; $display("FAIL rst_press got=%h exp=0", key_press); end
    total++; if (key_event !== 4'h0) begin bad++; $display("FAIL rst_event got=%h exp=0", key_event); end
    total++; if (led_out !== 18'h0) begin bad++; $display("FAIL rst_led got=%h exp=0", led_out); end
    rst_n = 1'b1;
    step();
    total++; if (led_out !== 18'h3FFFF) begin bad++; $display("FAIL rst_led_after got=%h exp=3ffff", led_out); end
    repeat (4) step();
    total++; if (key_level !== 4'h0) begin bad++; $display("FAIL rst_level_e4 got=%h exp=0", key_level); end
    step();
    total++; if (key_level !== 4'hF) begin bad++; $display("FAIL rst_level_e5 got=%h exp=f", key_level); end
    step();
    total++; if (key_press !== 4'hF) begin bad++; $display("FAIL rst_press_e6 got=%h exp=f", key_press); end
    step();
    total++; if (key_press !== 4'h0) begin bad++; $display("FAIL rst_press_e7 got=%h exp=0", key_press); end
    total++; if (key_event !== 4'hF) begin bad++; $display("FAIL rst_event_e7 got=%h exp=f", key_event); end
    led_data = 18'h15A5A;
    step();
    total++; if (led_out !== 18'h15A5A) begin bad++; $display("FAIL direct_led got=%h exp=15a5a", led_out); end
    key_raw = '1;
    repeat (5) step();
    total++; if (key_level !== 4'hF) begin bad++; $display("FAIL rel_level_e4 got=%h exp=f", key_level); end
    step();
    total++; if (key_level !== 4'h0) begin bad++; $display("FAIL rel_level_e5 got=%h exp=0", key_level); end
    key_clr = '1;
    step();
    key_clr = '0;
    total++; if (key_event !== 4'h0) begin bad++; $display("FAIL rst_clr_event got=%h exp=0", key_event); end
  endtask

  task automatic test_reset_mid();
    key_raw[2] = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    total++; if (led_out !== 18'h0) begin bad++; $display("FAIL mid_async_led got=%h exp=0", led_out); end
    total++; if (key_level !== 4'h0) begin bad++; $display("FAIL mid_async_level got=%h exp=0", key_level); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    total++; if (key_level[2] !== 1'b0) begin bad++; $display("FAIL mid_level_e4 got=%b exp=0", key_level[2]); end
    step();
    total++; if (key_level[2] !== 1'b1) begin bad++; $display("FAIL mid_level_e5 got=%b exp=1", key_level[2]); end
    repeat (2) step();
    total++; if (key_event !== 4'b0100) begin bad++; $display("FAIL mid_event got=%h exp=4", key_event); end
    key_raw = '1;
    repeat (6) step();
    key_clr = '1;
    step();
    key_clr = '0;
  endtask

  task automatic test_debounce_reject();
    int pulses;
    key_raw[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (key_level[0] !== 1'b0) begin bad++; $display("FAIL rej_a_level got=%b exp=0", key_level[0]); end
    end
    key_raw[0] = 1'b1;
    step();
    key_raw[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (key_level[0] !== 1'b0) begin bad++; $display("FAIL rej_b_level got=%b exp=0", key_level[0]); end
    end
    key_raw[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (key_level[0] !== 1'b0 || key_press[0] !== 1'b0) begin
        bad++; $display("FAIL rej_tail got=%b/%b exp=0/0", key_level[0], key_press[0]);
      end
    end
    key_raw[0] = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (key_press[0] === 1'b1) pulses++;
      if (i == 5) begin
        total++; if (key_level[0] !== 1'b0) begin bad++; $display("FAIL hold_level_e4 got=%b exp=0", key_level[0]); end
      end
      if (i == 6) begin
        total++; if (key_level[0] !== 1'b1) begin bad++; $display("FAIL hold_level_e5 got=%b exp=1", key_level[0]); end
      end
      if (i == 7) begin
        total++; if (key_press[0] !== 1'b1) begin bad++; $display("FAIL hold_press got=%b exp=1", key_press[0]); end
      end
      if (i == 8) begin
        total++; if (key_event[0] !== 1'b1) begin bad++; $display("FAIL hold_event got=%b exp=1", key_event[0]); end
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL hold_pulse_count got=%0d exp=1", pulses); end
    key_raw[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      total++; if (key_press[0] !== 1'b0) begin bad++; $display("FAIL release_press got=%b exp=0", key_press[0]); end
      if (i == 5) begin
        total++; if (key_level[0] !== 1'b1) begin bad++; $display("FAIL release_e4 got=%b exp=1", key_level[0]); end
      end
      if (i == 6) begin
        total++; if (key_level[0] !== 1'b0) begin bad++; $display("FAIL release_e5 got=%b exp=0", key_level[0]); end
      end
    end
    key_clr = 4'b0001;
    step();
    key_clr = '0;
    total++; if (key_event[0] !== 1'b0) begin bad++; $display("FAIL rej_clr got=%b exp=0", key_event[0]); end
  endtask

  task automatic test_sticky();
    key_raw[1] = 1'b0;
    repeat (8) step();
    total++; if (key_event[1] !== 1'b1) begin bad++; $display("FAIL sticky_set got=%b exp=1", key_event[1]); end
    key_raw[1] = 1'b1;
    repeat (6) step();
    total++; if (key_event[1] !== 1'b1) begin bad++; $display("FAIL sticky_hold got=%b exp=1", key_event[1]); end
    key_clr[1] = 1'b1;
    step();
    key_clr[1] = 1'b0;
    total++; if (key_event[1] !== 1'b0) begin bad++; $display("FAIL sticky_clr got=%b exp=0", key_event[1]); end
    step();
    total++; if (key_event[1] !== 1'b0) begin bad++; $display("FAIL sticky_stay0 got=%b exp=0", key_event[1]); end
    key_raw[1] = 1'b0;
    repeat (7) step();
    total++; if (key_press[1] !== 1'b1) begin bad++; $display("FAIL sticky_press got=%b exp=1", key_press[1]); end
    key_clr[1] = 1'b1;
    step();
    key_clr[1] = 1'b0;
    total++; if (key_event[1] !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b exp=1", key_event[1]); end
    step();
    total++; if (key_event[1] !== 1'b1) begin bad++; $display("FAIL sticky_after got=%b exp=1", key_event[1]); end
    key_raw[1] = 1'b1;
    repeat (6) step();
    key_clr = '1;
    step();
    key_clr = '0;
  endtask

  task automatic test_simultaneous();
    key_raw = '0;
    repeat (6) step();
    total++; if (key_level !== 4'hF) begin bad++; $display("FAIL simul_level got=%h exp=f", key_level); end
    step();
    total++; if (key_press !== 4'hF) begin bad++; $display("FAIL simul_press got=%h exp=f", key_press); end
    step();
    total++; if (key_press !== 4'h0) begin bad++; $display("FAIL simul_press_end got=%h exp=0", key_press); end
    total++; if (key_event !== 4'hF) begin bad++; $display("FAIL simul_event got=%h exp=f", key_event); end
    key_raw = '1;
    repeat (6) step();
    key_clr = '1;
    step();
    key_clr = '0;
  endtask

  task automatic test_pwm();
    logic [PB-1:0] duties [3];
    int            exp_high [3];
    int            highs;
    logic [NLED-1:0] exp_led;
    duties[0] = 3'd3; exp_high[0] = 3;
    duties[1] = 3'd0; exp_high[1] = 0;
    duties[2] = 3'd7; exp_high[2] = 7;
    led_mode = 2'b10;
    led_data = 18'h1;
    for (int d = 0; d < 3; d++) begin
      led_duty = duties[d];
      step();
      highs = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        exp_led = (((cyc - 1) % 8) < int'(duties[d])) ? 18'h1 : 18'h0;
        if (led_out[0] === 1'b1) highs++;
        total++; if (led_out !== exp_led) begin
          bad++; $display("FAIL pwm_cycle duty=%0d got=%h exp=%h", duties[d], led_out, exp_led);
        end
      end
      total++; if (highs != exp_high[d]) begin
        bad++; $display("FAIL pwm_count duty=%0d got=%0d exp=%0d", duties[d], highs, exp_high[d]);
      end
    end
  endtask

  task automatic test_blink_off();
    logic [NLED-1:0] exp_led;
    led_mode = 2'b01;
    led_data = 18'h2B3C5;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      exp_led = ((((cyc - 1) / 3) % 2) == 0) ? 18'h2B3C5 : 18'h0;
      total++; if (led_out !== exp_led) begin
        bad++; $display("FAIL blink_cycle cyc=%0d got=%h exp=%h", cyc, led_out, exp_led);
      end
    end
    led_mode = 2'b11;
    step();
    total++; if (led_out !== 18'h0) begin bad++; $display("FAIL off_led got=%h exp=0", led_out); end
    led_mode = 2'b00;
    step();
    total++; if (led_out !== 18'h2B3C5) begin bad++; $display("FAIL direct_back got=%h exp=2b3c5", led_out); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid();
    test_debounce_reject();
    test_sticky();
    test_simultaneous();
    test_pwm();
    test_blink_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board-level I/O controller sitting between the FPGA pins and `veriRISCV_soc`. It debounces and synchronises N active-low pushbuttons into clean levels, one-cycle press pulses and sticky press events. It drives N LEDs from a GPIO word in one of four global display modes: direct, blink, PWM-dimmed or off. It replaces the hard-wired pin assignments in board top levels, so every board wrapper instantiates it between the pins and the SoC GPIO ports.

## Interface

- `NKEY`, 4: number of pushbutton channels (1..32).
- `NLED`, 18: number of LED outputs (1..32).
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a key change (20 ms at 50 MHz); must be ≥ 2.
- `BLINK_DIV`, 12500000: cycles per blink half-period; must be ≥ 1.
- `PWM_BITS`, 8: PWM counter and duty width.

Ports:

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_raw`  in  NKEY  pushbutton pins, active-low (0 = pressed), asynchronous to `clk`.
- `key_level`  out  NKEY  debounced key state, active-high (1 = pressed).
- `key_press`  out  NKEY  one-cycle pulse on each debounced press.
- `key_event`  out  NKEY  sticky press flag per key.
- `key_clr`  in  NKEY  per-key clear of `key_event`.
- `led_data`  in  NLED  LED pattern from the SoC GPIO.
- `led_mode`  in  2  00 direct, 01 blink, 10 PWM, 11 off.
- `led_duty`  in  PWM_BITS  PWM on-count.
- `led_out`  out  NLED  registered LED pin drive, active-high.

## Operation

- **Synchroniser:** each `key_raw` bit passes through a 2-flop synchroniser. Both flops reset to 1 (released). The synchronised value is inverted to an active-high `pressed` signal.
- **Debounce, per channel:**
  - Each channel has a counter of width clog2(DEBOUNCE_CYCLES) and a `stable` register that resets to 0.
  - When `pressed` equals `stable`, the counter clears to 0.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 while still differing, `stable` takes `pressed` and the counter clears.
  - Any single-cycle bounce back to `stable` restarts the count from 0.
  - `key_level` = `stable`.
- **Press pulse:** `key_press[i]` is registered and asserts for exactly one cycle, on the cycle after `stable[i]` rises 0→1. A release (1→0) produces no pulse.
- **Sticky event:** `key_event[i]` sets on `key_press[i]` and clears on `key_clr[i]`. If both occur in the same cycle, the set wins. The flag holds otherwise.
- **Blink timer:** a free-running counter runs 0..BLINK_DIV-1. On wrap, `blink_phase` toggles. `blink_phase` resets to 1, so LEDs start on.
- **PWM:** a free-running PWM_BITS counter wraps naturally at 2^PWM_BITS. `pwm_on` = (cnt < `led_duty`), unsigned compare.
  - Duty 0 gives always off.
  - Duty 2^PWM_BITS-1 gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
  - A duty change takes effect on the next compare; there is no period alignment.
- **LED mux**, registered into `led_out`:
  - 00: `led_data`.
  - 01: `led_data` & {NLED{blink_phase}}.
  - 10: `led_data` & {NLED{pwm_on}}.
  - 11: all zero.
- **Counter independence:** the blink and PWM counters run continuously regardless of mode. A mode change does not restart them.

## Timing

- **Reset values:** `key_level`=0, `key_press`=0, `key_event`=0 and `led_out`=0. All counters are 0 and `blink_phase`=1.
  - Reset is asynchronous on assertion.
  - Reset asserted mid-debounce discards the count; the key must be held the full window again after release of reset.
- **Key latency:**
  - Let edge E be the first rising `clk` edge that samples `key_raw` low.
  - The synchroniser output changes at E+1.
  - `key_level` rises at edge E+1+DEBOUNCE_CYCLES.
  - `key_press` is high for the single cycle following that edge, i.e. it is set at E+2+DEBOUNCE_CYCLES.
  - Release has the same latency on `key_level`.
- **Key timing boundary:** a press held for exactly DEBOUNCE_CYCLES-1 synchronised cycles is rejected.
- **LED latency:** one cycle from `led_data`, `led_mode` or `led_duty` to `led_out`.
- **Key independence:** all keys are processed independently. Simultaneous presses each produce their own pulse in the same cycle.

## Test plan

Sim parameters: DEBOUNCE_CYCLES=4, BLINK_DIV=3, PWM_BITS=3.

- **Reset:** hold `rst_n`=0 with `key_raw`=0 and `led_data`=all 1s, mode 00 → all outputs 0. One cycle after release, `led_out`=all 1s. `key_level` rises at E+5, counting from the first post-reset sampling edge E.
- **Debounce reject:** `key_raw[0]` low for 3 cycles, high 1, low 3 → `key_level[0]` never rises and `key_press[0]` stays 0. Then hold low 10 cycles → `key_level[0]` rises at E+5, `key_press[0]` pulses once, `key_event[0]`=1.
- **Sticky flag:** with `key_event[1]`=1, pulse `key_clr[1]` → 0 next cycle. Assert `key_clr[1]` in the same cycle as `key_press[1]` → `key_event[1]` stays 1.
- **Simultaneous keys:** all 4 keys pressed on the same edge → 4 pulses in the same cycle, `key_event`=4'b1111.
- **PWM:** mode 10, `led_duty`=3, `led_data`=1 → `led_out[0]` high 3 of every 8 cycles. Duty 0 → always 0. Duty 7 → high 7 of 8.
- **Blink / off:** mode 01 → `led_out` toggles between pattern and 0 every 3 cycles, starting on. Mode 11 → 0 one cycle later.
